// File: rtl/rv32_scoreboard_pkg.sv
// Shared types and helpers for the long-latency write scoreboard.
// The entry layout and register-index folding are used by the top and the match units.
package rv32_scoreboard_pkg;

  typedef struct packed {
    logic       valid;
    logic       committed;
    logic [4:0] rd;
  } sb_entry_t;

  // RV32E has 16 architectural registers, so only index bits [3:0] take part in compares
  function automatic logic [4:0] reg_index(input logic [4:0] r, input logic rv32e);
    return rv32e ? {1'b0, r[3:0]} : r;
  endfunction

endpackage

// File: rtl/rv32_scoreboard_match.sv
// Hit detector for one decode query port.
// It reports whether any valid scoreboard entry targets the queried non-zero register.
module rv32_scoreboard_match
  import rv32_scoreboard_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter bit RV32E = 1'b0
) (
  input  logic               en_i,
  input  logic [4:0]         reg_i,
  input  logic [DEPTH-1:0]   valid_i,
  input  logic [DEPTH*5-1:0] rd_i,
  output logic               hit_o
);

  logic [4:0] reg_idx;

  always_comb begin
    reg_idx = reg_index(reg_i, RV32E);
    hit_o   = 1'b0;
    // x0 is never tracked, even though an x0 destination still occupies a slot
    if (en_i && (reg_idx != 5'd0)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_i[i] && (reg_index(rd_i[i*5 +: 5], RV32E) == reg_idx)) begin
          hit_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rv32_scoreboard.sv
// Scoreboard for outstanding long-latency register writes: a circular FIFO with head/commit/tail
// pointers drives a decode stall on RAW/WAW hazards or when the FIFO is full.
module rv32_scoreboard
  import rv32_scoreboard_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  parameter bit RV32E = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4:0]              decode_rs1_in,
  input  logic                    decode_rs1_read_in,
  input  logic [4:0]              decode_rs2_in,
  input  logic                    decode_rs2_read_in,
  input  logic [4:0]              decode_rd_in,
  input  logic                    decode_rd_write_in,
  input  logic                    issue_valid_in,
  input  logic [4:0]              issue_rd_in,
  input  logic                    commit_in,
  input  logic                    flush_in,
  input  logic                    complete_in,
  output logic                    stall_out,
  output logic                    full_out,
  output logic [$clog2(DEPTH):0]  count_out,
  output logic [CNT_W-1:0]        stall_cycles_out,
  output logic                    protocol_err_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  sb_entry_t        entries_q [DEPTH];
  sb_entry_t        entries_d [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    cmt_q, cmt_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             perr_q, perr_d;

  logic [DEPTH-1:0]   valid_vec;
  logic [DEPTH*5-1:0] rd_vec;
  logic [PW-1:0]      count_w;
  logic               full_w;
  logic               stall_w;
  logic               hit_rs1, hit_rs2, hit_rd;
  logic               do_commit;
  logic [PW-1:0]      pending;
  logic [AW-1:0]      rel;

  always_comb begin
    valid_vec = '0;
    rd_vec    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i]      = entries_q[i].valid;
      rd_vec[i*5 +: 5]  = entries_q[i].rd;
    end
  end

  assign count_w = tail_q - head_q;
  assign full_w  = (count_w == PW'(DEPTH));

  rv32_scoreboard_match #(.DEPTH(DEPTH), .RV32E(RV32E)) u_match_rs1 (
    .en_i    (decode_rs1_read_in),
    .reg_i   (decode_rs1_in),
    .valid_i (valid_vec),
    .rd_i    (rd_vec),
    .hit_o   (hit_rs1)
  );

  rv32_scoreboard_match #(.DEPTH(DEPTH), .RV32E(RV32E)) u_match_rs2 (
    .en_i    (decode_rs2_read_in),
    .reg_i   (decode_rs2_in),
    .valid_i (valid_vec),
    .rd_i    (rd_vec),
    .hit_o   (hit_rs2)
  );

  rv32_scoreboard_match #(.DEPTH(DEPTH), .RV32E(RV32E)) u_match_rd (
    .en_i    (decode_rd_write_in),
    .reg_i   (decode_rd_in),
    .valid_i (valid_vec),
    .rd_i    (rd_vec),
    .hit_o   (hit_rd)
  );

  // Full uses the start-of-cycle count, so a same-cycle completion never frees a slot
  assign stall_w = hit_rs1 | hit_rs2 | hit_rd | (issue_valid_in & full_w);

  // Events apply in order commit, complete, flush, issue; each step sees the previous one's result
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    cmt_d     = cmt_q;
    tail_d    = tail_q;
    perr_d    = perr_q;
    pending   = '0;
    rel       = '0;

    do_commit = commit_in && (cmt_q != tail_q);
    if (commit_in && !do_commit) begin
      perr_d = 1'b1;
    end
    if (do_commit) begin
      entries_d[cmt_q[AW-1:0]].committed = 1'b1;
      cmt_d = cmt_q + PW'(1);
    end

    if (complete_in) begin
      if ((head_q == tail_q) || !entries_d[head_q[AW-1:0]].committed) begin
        perr_d = 1'b1;
      end else begin
        entries_d[head_q[AW-1:0]] = '0;
        head_d = head_q + PW'(1);
      end
    end

    if (flush_in) begin
      pending = tail_q - cmt_d;
      for (int i = 0; i < DEPTH; i++) begin
        rel = AW'(i) - cmt_d[AW-1:0];
        if ({1'b0, rel} < pending) begin
          entries_d[i] = '0;
        end
      end
      tail_d = cmt_d;
    end else if (issue_valid_in && !stall_w) begin
      entries_d[tail_q[AW-1:0]].valid     = 1'b1;
      entries_d[tail_q[AW-1:0]].committed = 1'b0;
      entries_d[tail_q[AW-1:0]].rd        = issue_rd_in;
      tail_d = tail_q + PW'(1);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_w && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q      <= '0;
      cmt_q       <= '0;
      tail_q      <= '0;
      stall_cnt_q <= '0;
      perr_q      <= 1'b0;
    end else begin
      entries_q   <= entries_d;
      head_q      <= head_d;
      cmt_q       <= cmt_d;
      tail_q      <= tail_d;
      stall_cnt_q <= stall_cnt_d;
      perr_q      <= perr_d;
    end
  end

  assign stall_out        = stall_w;
  assign full_out         = full_w;
  assign count_out        = count_w;
  assign stall_cycles_out = stall_cnt_q;
  assign protocol_err_out = perr_q;

endmodule

// File: tb/tb_rv32_scoreboard.sv
// Directed bench for rv32_scoreboard: stimulus queues hand-computed expectations,
// and a negedge monitor pops and compares them against the live outputs.
module tb_rv32_scoreboard;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  localparam int S_STALL = 0;
  localparam int S_FULL  = 1;
  localparam int S_COUNT = 2;
  localparam int S_SCYC  = 3;
  localparam int S_PERR  = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [4:0]        decode_rs1_in, decode_rs2_in, decode_rd_in, issue_rd_in;
  logic              decode_rs1_read_in, decode_rs2_read_in, decode_rd_write_in;
  logic              issue_valid_in, commit_in, flush_in, complete_in;
  logic              stall_out, full_out, protocol_err_out;
  logic [2:0]        count_out;
  logic [CNT_W-1:0]  stall_cycles_out;

  always #5 clk = ~clk;

  rv32_scoreboard #(.DEPTH(DEPTH), .CNT_W(CNT_W), .RV32E(1'b0)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .decode_rs1_in      (decode_rs1_in),
    .decode_rs1_read_in (decode_rs1_read_in),
    .decode_rs2_in      (decode_rs2_in),
    .decode_rs2_read_in (decode_rs2_read_in),
    .decode_rd_in       (decode_rd_in),
    .decode_rd_write_in (decode_rd_write_in),
    .issue_valid_in     (issue_valid_in),
    .issue_rd_in        (issue_rd_in),
    .commit_in          (commit_in),
    .flush_in           (flush_in),
    .complete_in        (complete_in),
    .stall_out          (stall_out),
    .full_out           (full_out),
    .count_out          (count_out),
    .stall_cycles_out   (stall_cycles_out),
    .protocol_err_out   (protocol_err_out)
  );

  typedef struct {
    string       name;
    int          sig;
    int unsigned exp;
  } chk_t;

  chk_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic exp_chk(input string name, input int sig, input int unsigned exp);
    chk_t c;
    c.name = name;
    c.sig  = sig;
    c.exp  = exp;
    q.push_back(c);
  endtask

  always @(negedge clk) begin : monitor
    chk_t        c;
    int unsigned act;
    while (q.size() > 0) begin
      c = q.pop_front();
      case (c.sig)
        S_STALL: act = 32'(stall_out);
        S_FULL:  act = 32'(full_out);
        S_COUNT: act = 32'(count_out);
        S_SCYC:  act = 32'(stall_cycles_out);
        default: act = 32'(protocol_err_out);
      endcase
      n_total++;
      if (act == c.exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", c.name, act, c.exp);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    decode_rs1_in = 0; decode_rs1_read_in = 0;
    decode_rs2_in = 0; decode_rs2_read_in = 0;
    decode_rd_in  = 0; decode_rd_write_in = 0;
    issue_valid_in = 0; issue_rd_in = 0;
    commit_in = 0; flush_in = 0; complete_in = 0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdv;
    clr();
    reset_n = 1'b0;
    step(); step();
    n_total++;
    if (count_out == 3'd0) n_pass++;
    else $display("FAIL rst_count_now: got %0d expected 0", count_out);
    n_total++;
    if (stall_out == 1'b0) n_pass++;
    else $display("FAIL rst_stall_now: got %0d expected 0", stall_out);
    exp_chk("rst_stall", S_STALL, 0);
    exp_chk("rst_count", S_COUNT, 0);
    exp_chk("rst_full",  S_FULL,  0);
    exp_chk("rst_scyc",  S_SCYC,  0);
    exp_chk("rst_perr",  S_PERR,  0);
    step();
    reset_n = 1'b1;

    // Basic RAW stall: issue x5, commit, then query rs1=x5 until completion is visible
    issue_valid_in = 1; issue_rd_in = 5;
    exp_chk("raw_issue_stall", S_STALL, 0);
    step(); clr();
    commit_in = 1;
    exp_chk("raw_count1", S_COUNT, 1);
    step(); clr();
    decode_rs1_in = 5; decode_rs1_read_in = 1;
    exp_chk("raw_stall_a", S_STALL, 1);
    step();
    exp_chk("raw_stall_b", S_STALL, 1);
    exp_chk("raw_scyc1",   S_SCYC,  1);
    step();
    complete_in = 1;
    exp_chk("raw_stall_complete", S_STALL, 1);
    exp_chk("raw_scyc2", S_SCYC, 2);
    step();
    complete_in = 0;
    exp_chk("raw_released", S_STALL, 0);
    exp_chk("raw_scyc3",    S_SCYC,  3);
    exp_chk("raw_count0",   S_COUNT, 0);
    step(); clr();

    // Full and x0 behaviour
    for (int i = 1; i <= 4; i++) begin
      issue_valid_in = 1; issue_rd_in = 5'(i);
      exp_chk("fill_stall", S_STALL, 0);
      step();
    end
    issue_valid_in = 1; issue_rd_in = 7;
    exp_chk("full_flag",   S_FULL,  1);
    exp_chk("full_count",  S_COUNT, 4);
    exp_chk("full_stall5", S_STALL, 1);
    step(); clr();
    decode_rs1_in = 0; decode_rs1_read_in = 1;
    exp_chk("x0_nostall",   S_STALL, 0);
    exp_chk("full_count_b", S_COUNT, 4);
    step(); clr();
    decode_rs1_in = 4; decode_rs1_read_in = 1;
    exp_chk("rs1_hit", S_STALL, 1);
    step(); clr();
    decode_rs2_in = 2; decode_rs2_read_in = 1;
    exp_chk("rs2_hit", S_STALL, 1);
    step(); clr();
    decode_rd_in = 3; decode_rd_write_in = 1;
    exp_chk("waw_hit", S_STALL, 1);
    step(); clr();
    decode_rs1_in = 1; decode_rs2_in = 1; decode_rd_in = 1;
    exp_chk("no_enable_nostall", S_STALL, 0);
    exp_chk("full_scyc", S_SCYC, 7);
    step(); clr();
    repeat (4) begin
      commit_in = 1; complete_in = 1;
      step();
    end
    clr();
    exp_chk("drain_count", S_COUNT, 0);
    exp_chk("drain_perr",  S_PERR,  0);
    step();

    // Flush kills the uncommitted x9 but keeps the committed x3
    issue_valid_in = 1; issue_rd_in = 3;
    step(); clr();
    commit_in = 1;
    step(); clr();
    issue_valid_in = 1; issue_rd_in = 9;
    step(); clr();
    flush_in = 1;
    step(); clr();
    exp_chk("flush_count", S_COUNT, 1);
    decode_rs1_in = 9; decode_rs1_read_in = 1;
    exp_chk("flush_x9_nostall", S_STALL, 0);
    step();
    decode_rs1_in = 3;
    exp_chk("flush_x3_stall", S_STALL, 1);
    step(); clr();
    complete_in = 1;
    step(); clr();
    exp_chk("flush_drain_count", S_COUNT, 0);
    exp_chk("flush_drain_perr",  S_PERR,  0);
    step();

    // All four events in one cycle with head committed and second entry uncommitted
    issue_valid_in = 1; issue_rd_in = 10;
    step(); clr();
    commit_in = 1;
    step(); clr();
    issue_valid_in = 1; issue_rd_in = 11;
    step(); clr();
    commit_in = 1; complete_in = 1; flush_in = 1;
    issue_valid_in = 1; issue_rd_in = 12;
    exp_chk("sim_count_before", S_COUNT, 2);
    step(); clr();
    exp_chk("sim_count", S_COUNT, 1);
    decode_rs1_in = 12; decode_rs1_read_in = 1;
    exp_chk("sim_issue_absent", S_STALL, 0);
    step();
    decode_rs1_in = 11;
    exp_chk("sim_x11_present", S_STALL, 1);
    step(); clr();
    complete_in = 1;
    step(); clr();
    exp_chk("sim_second_committed_count", S_COUNT, 0);
    exp_chk("sim_second_committed_perr",  S_PERR,  0);
    exp_chk("sim_scyc", S_SCYC, 9);
    step();

    // Wrap-around: pointers lap the FIFO three times
    for (int i = 0; i < 3*DEPTH; i++) begin
      rdv = 1 + ((i * 7) % 31);
      issue_valid_in = 1; issue_rd_in = 5'(rdv);
      exp_chk("wrap_issue_stall", S_STALL, 0);
      step(); clr();
      commit_in = 1; decode_rs1_in = 5'(rdv); decode_rs1_read_in = 1;
      exp_chk("wrap_hit",   S_STALL, 1);
      exp_chk("wrap_count", S_COUNT, 1);
      step(); clr();
      complete_in = 1;
      step(); clr();
      decode_rs1_in = 5'(rdv); decode_rs1_read_in = 1;
      exp_chk("wrap_no_spurious", S_STALL, 0);
      exp_chk("wrap_count0",      S_COUNT, 0);
      step(); clr();
    end
    exp_chk("wrap_scyc", S_SCYC, 21);
    exp_chk("wrap_perr", S_PERR, 0);

    // Protocol error: complete and commit on an empty FIFO
    complete_in = 1;
    step(); clr();
    exp_chk("perr_set",   S_PERR,  1);
    exp_chk("perr_count", S_COUNT, 0);
    commit_in = 1;
    step(); clr();
    exp_chk("perr_commit_count", S_COUNT, 0);
    exp_chk("perr_sticky",       S_PERR,  1);
    step();

    // Reset mid-stream with a live hazard
    issue_valid_in = 1; issue_rd_in = 6;
    step(); clr();
    decode_rs1_in = 6; decode_rs1_read_in = 1;
    exp_chk("pre_rst_stall", S_STALL, 1);
    exp_chk("pre_rst_scyc",  S_SCYC,  21);
    step();
    reset_n = 1'b0;
    #1;
    n_total++;
    if (stall_cycles_out == 16'd0) n_pass++;
    else $display("FAIL midrst_scyc_now: got %0d expected 0", stall_cycles_out);
    n_total++;
    if (protocol_err_out == 1'b0) n_pass++;
    else $display("FAIL midrst_perr_now: got %0d expected 0", protocol_err_out);
    n_total++;
    if (count_out == 3'd0) n_pass++;
    else $display("FAIL midrst_count_now: got %0d expected 0", count_out);
    exp_chk("midrst_stall", S_STALL, 0);
    exp_chk("midrst_count", S_COUNT, 0);
    exp_chk("midrst_full",  S_FULL,  0);
    exp_chk("midrst_scyc",  S_SCYC,  0);
    exp_chk("midrst_perr",  S_PERR,  0);
    step();
    reset_n = 1'b1;
    exp_chk("postrst_stall", S_STALL, 0);
    step(); clr();

    // Stall counter saturation
    issue_valid_in = 1; issue_rd_in = 8;
    step(); clr();
    decode_rs1_in = 8; decode_rs1_read_in = 1;
    repeat (65534) step();
    n_total++;
    if (stall_cycles_out == 16'd65534) n_pass++;
    else $display("FAIL sat_pre_now: got %0d expected 65534", stall_cycles_out);
    exp_chk("sat_pre", S_SCYC, 65534);
    repeat (70000 - 65534) step();
    n_total++;
    if (stall_cycles_out == 16'd65535) n_pass++;
    else $display("FAIL sat_hold_now: got %0d expected 65535", stall_cycles_out);
    exp_chk("sat_hold",  S_SCYC,  65535);
    exp_chk("sat_stall", S_STALL, 1);
    step(); clr();
    step();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
